register: RTL and testbench

REGISTER -- requirements
Module: register

---
 rtl/register_pkg.sv | 26 ++
 rtl/register_bit.sv | 53 +++++
 rtl/register.sv | 75 +++++++
 tb/tb_register.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// ---------------------------------------------------------------------------
// register_pkg
//
// Shared constants and helpers for the register block and its testbench.
//
// Contents:
//   REGISTER_DEFAULT_WIDTH   - default data width of the register (bits)
//   REGISTER_DEFAULT_RST_VAL - default reset value of the register
//   parity()                 - XOR-reduction of a value (even parity bit),
//                              used by the RTL for the optional parity
//                              output and by the bench for expected values
//
// Optional feature macro used by the block: REGISTER_PARITY_EN
// ---------------------------------------------------------------------------
package register_pkg;

    localparam int REGISTER_DEFAULT_WIDTH   = 4;
    localparam int REGISTER_DEFAULT_RST_VAL = 0;

    // Returns 1 when value has an odd number of ones. Callers zero-extend
    // narrower vectors, which leaves the result unchanged.
    function automatic logic parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage : register_pkg

// File: rtl/register_bit.sv
// ---------------------------------------------------------------------------
// register_bit
//
// One flop with asynchronous active-low reset, a per-instance reset value
// and a load enable. The register top level builds its data word (and the
// optional parity bit) out of these.
//
// Parameters:
//   RST_BIT  - value q_o takes while rst_ni is low
//
// Ports:
//   clk_i    - clock, rising-edge active
//   rst_ni   - asynchronous reset, active low
//   load_i   - capture enable, active high
//   d_i      - data bit to capture
//   q_o      - registered bit, driven directly from the flop
// ---------------------------------------------------------------------------
module register_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic d_i,
    output logic q_o
);

    logic q_d;
    logic q_q;

    // Next-state selection. The if-form (rather than a ternary) makes an
    // unknown load_i fall through to the hold value instead of merging
    // d_i and q_q into X.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end
    end

    // State flop: reset is asynchronous, so q_q goes to RST_BIT as soon as
    // rst_ni falls and stays there until an edge after rst_ni is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : register_bit

// File: rtl/register.sv
// ---------------------------------------------------------------------------
// register
//
// WIDTH-bit load-enabled register with asynchronous active-low reset.
// Q is captured from D on a rising clk edge when load is high and held
// otherwise; all bits load together with one clock of latency.
//
// Parameters:
//   WIDTH    - data width in bits (1..32)
//   RST_VAL  - value Q takes while rst is low
//
// Ports:
//   clk      - clock, rising-edge active
//   rst      - asynchronous reset, active low (0 = reset asserted)
//   load     - capture enable, active high
//   D        - data to capture
//   Q        - registered value, driven directly from flops
//   par      - XOR of all Q bits, registered alongside Q
//              (only present when REGISTER_PARITY_EN is defined)
//
// Configuration macro: REGISTER_PARITY_EN
//   Defined   - adds the par output and one extra register_bit for it.
//   Undefined - par and its logic are absent; Q behaves identically.
// ---------------------------------------------------------------------------
module register
    import register_pkg::*;
#(
    parameter int               WIDTH   = REGISTER_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(REGISTER_DEFAULT_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
`ifdef REGISTER_PARITY_EN
    ,
    output logic             par
`endif
);

    // One flop per data bit, each with its own slice of RST_VAL. Every bit
    // shares the same load enable so the word is always written whole.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        register_bit #(
            .RST_BIT (RST_VAL[i])
        ) u_bit (
            .clk_i  (clk),
            .rst_ni (rst),
            .load_i (load),
            .d_i    (D[i]),
            .q_o    (Q[i])
        );
    end

`ifdef REGISTER_PARITY_EN
    // Parity is computed from D and captured on the same edge as Q, so par
    // always equals the XOR of the current Q without a combinational path
    // from Q. Its reset value is the parity of RST_VAL to stay consistent.
    logic parD;

    assign parD = parity(32'(D));

    register_bit #(
        .RST_BIT (parity(32'(RST_VAL)))
    ) u_par (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (load),
        .d_i    (parD),
        .q_o    (par)
    );
`endif

endmodule : register

// File: tb/tb_register.sv
// ---------------------------------------------------------------------------
// tb_register
//
// Directed self-checking bench for the register block at its default
// parameters (WIDTH=4, RST_VAL=0). Inputs change on the falling clk edge;
// outputs are sampled 1 time unit after the rising edge. Parity checks are
// included when REGISTER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_register;

    import register_pkg::*;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
`ifdef REGISTER_PARITY_EN
    logic             par;
`endif

    int checks;
    int failures;

    register #(
        .WIDTH   (WIDTH),
        .RST_VAL (4'h0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .D    (D),
        .Q    (Q)
`ifdef REGISTER_PARITY_EN
        ,
        .par  (par)
`endif
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drives a new input vector on the falling edge, midway between edges.
    task automatic applyStimulus(input logic [WIDTH-1:0] dVal,
                                 input logic rstVal, input logic loadVal);
        @(negedge clk);
        D    = dVal;
        rst  = rstVal;
        load = loadVal;
    endtask

    // Advances past the next rising edge to a stable sampling point.
    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] model;
    logic [5:0]       vec;

    initial begin
        checks   = 0;
        failures = 0;

        // Reset state: asserted from time 0.
        rst  = 1'b0;
        load = 1'b0;
        D    = 4'h0;
        #1;
        checkOutput("reset_q", Q, 4'h0);
        waitEdge();
        checkOutput("reset_q_clocked", Q, 4'h0);

        // Load: D=5 then D=9 on consecutive edges, one clock latency each.
        applyStimulus(4'h5, 1'b1, 1'b1);
        checkOutput("load_no_comb", Q, 4'h0);
        waitEdge();
        checkOutput("load_5", Q, 4'h5);
        applyStimulus(4'h9, 1'b1, 1'b1);
        checkOutput("load_9_before_edge", Q, 4'h5);
        waitEdge();
        checkOutput("load_9", Q, 4'h9);

        // Hold: D sweeps 0..F with load low, Q keeps 9.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(WIDTH'(i), 1'b1, 1'b0);
            waitEdge();
            checkOutput($sformatf("hold_%0d", i), Q, 4'h9);
        end

        // Async reset between edges from Q=A, then held while load=1, D=F.
        applyStimulus(4'hA, 1'b1, 1'b1);
        waitEdge();
        checkOutput("preload_a", Q, 4'hA);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", Q, 4'h0);
        load = 1'b1;
        D    = 4'hF;
        waitEdge();
        checkOutput("reset_hold_1", Q, 4'h0);
        waitEdge();
        checkOutput("reset_hold_2", Q, 4'h0);

        // Sweep {D,rst,load} = 0..61 against a reference model.
        model = 4'h0;
        for (int v = 0; v < 62; v++) begin
            vec = 6'(v);
            applyStimulus(vec[5:2], vec[1], vec[0]);
            if (!vec[1]) begin
                model = 4'h0;
            end else if (vec[0]) begin
                model = vec[5:2];
            end
            waitEdge();
            checkOutput($sformatf("sweep_%0d", v), Q, model);
`ifdef REGISTER_PARITY_EN
            checkOutput($sformatf("sweep_par_%0d", v), par,
                        parity(32'(model)));
`endif
        end

        // Reset released on the same edge that sees load=1, D=3. The
        // nonblocking drive lands after the flops have sampled that edge.
        applyStimulus(4'h3, 1'b0, 1'b1);
        #1;
        checkOutput("release_pre", Q, 4'h0);
        @(posedge clk);
        rst <= 1'b1;
        #1;
        checkOutput("release_edge", Q, 4'h0);
        waitEdge();
        checkOutput("release_next", Q, 4'h3);

        // Unknown load must hold.
        applyStimulus(4'hC, 1'b1, 1'bx);
        waitEdge();
        checkOutput("x_load_hold", Q, 4'h3);

`ifdef REGISTER_PARITY_EN
        // Parity output.
        applyStimulus(4'h7, 1'b1, 1'b1);
        waitEdge();
        checkOutput("par_7", par, 1'b1);
        applyStimulus(4'h6, 1'b1, 1'b1);
        waitEdge();
        checkOutput("par_6", par, 1'b0);
        applyStimulus(4'h7, 1'b1, 1'b1);
        waitEdge();
        checkOutput("par_7_again", par, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("par_reset", par, 1'b0);
        checkOutput("par_reset_q", Q, 4'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register
